// File: rtl/data_mem_resp_pkg.sv
// Shared types and constants for the data-memory responder.
// Imported by the top-level FSM and its RAM.
package data_mem_resp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    READ,
    ACK,
    RELEASE
  } dmr_state_t;

  localparam int DMR_WORD_SHIFT = 2;
  localparam int DMR_WAIT_CNT_W = 4;

endpackage

// File: rtl/data_mem_ram.sv
// Single-port synchronous RAM with registered read port.
// Only the read register is reset; the array is not.
module data_mem_ram #(
  parameter int DW = 32,
  parameter int AW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)  r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory port responder: request FSM, capture regs and checks.
// Services level-held strobes from an internal RAM with a 1-cycle ack.
module data_mem_responder
  import data_mem_resp_pkg::*;
#(
  parameter int DATAWIDTH_BUS      = 32,
  parameter int DATAWIDTH_MEM_ADDR = 8,
  parameter int WAIT_STATES        = 0
) (
  input  logic                     DataMemResp_CLOCK_50,
  input  logic                     DataMemResp_RESET_InLow,
  input  logic                     DataMemResp_Selector_RD,
  input  logic                     DataMemResp_Selector_WR,
  input  logic [DATAWIDTH_BUS-1:0] DataMemResp_Address_In,
  input  logic [DATAWIDTH_BUS-1:0] DataMemResp_Data_In,
  output logic [DATAWIDTH_BUS-1:0] DataMemResp_Data_Out,
  output logic                     DataMemResp_Ack_Out,
  output logic                     DataMemResp_Error_Out
);

  localparam int DW = DATAWIDTH_BUS;
  localparam int AW = DATAWIDTH_MEM_ADDR;
  localparam int CW = DMR_WAIT_CNT_W;
  localparam bit HAS_WAIT = (WAIT_STATES > 0);
  localparam logic [CW-1:0] WS_LOAD =
    CW'(HAS_WAIT ? WAIT_STATES - 1 : 0);

  logic          w_clk;
  logic          w_rst_n;
  logic          w_rd;
  logic          w_wr;
  logic          w_req;
  logic          w_bad;
  logic [AW-1:0] w_in_idx;
  logic          w_we;
  logic          w_re;
  logic [AW-1:0] w_ram_addr;
  logic [DW-1:0] w_ram_wdata;
  logic [DW-1:0] w_rdata;

  dmr_state_t    r_state;
  dmr_state_t    w_next;
  logic [AW-1:0] r_idx;
  logic [DW-1:0] r_wdata;
  logic          r_rd;
  logic          r_err;
  logic [CW-1:0] r_cnt;

  assign w_clk    = DataMemResp_CLOCK_50;
  assign w_rst_n  = DataMemResp_RESET_InLow;
  assign w_rd     = DataMemResp_Selector_RD;
  assign w_wr     = DataMemResp_Selector_WR;
  assign w_req    = w_rd | w_wr;
  assign w_in_idx =
    DataMemResp_Address_In[AW+DMR_WORD_SHIFT-1:DMR_WORD_SHIFT];

  // Conflict, misalignment or any address bit above the RAM range.
  assign w_bad = (w_rd & w_wr)
    | (DataMemResp_Address_In[DMR_WORD_SHIFT-1:0] != '0)
    | ((DataMemResp_Address_In >> (AW + DMR_WORD_SHIFT)) != '0);

  always_ff @(posedge w_clk) begin
    if (!w_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_req) begin
          if (w_bad)         w_next = ACK;
          else if (HAS_WAIT) w_next = WAIT;
          else if (w_rd)     w_next = READ;
          else               w_next = ACK;
        end
      end
      WAIT: begin
        if (r_cnt == '0) w_next = r_rd ? READ : ACK;
      end
      READ:    w_next = ACK;
      ACK:     w_next = RELEASE;
      RELEASE: if (!w_req) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    DataMemResp_Ack_Out   = (r_state == ACK);
    DataMemResp_Error_Out = (r_state == ACK) & r_err;
  end

  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      r_idx   <= '0;
      r_wdata <= '0;
      r_rd    <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (r_state == IDLE && w_req) begin
        r_idx   <= w_in_idx;
        r_wdata <= DataMemResp_Data_In;
        r_rd    <= w_rd;
        r_err   <= w_bad;
      end
      if (r_state != WAIT && w_next == WAIT) r_cnt <= WS_LOAD;
      else if (r_state == WAIT && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
    end
  end

  // Zero-wait writes commit straight from the IDLE sample.
  assign w_we = w_rst_n & (
    (r_state == IDLE && w_req && !w_bad && w_wr && !HAS_WAIT)
    | (r_state == WAIT && w_next == ACK));
  assign w_re        = (r_state == READ);
  assign w_ram_addr  = (r_state == IDLE) ? w_in_idx : r_idx;
  assign w_ram_wdata = (r_state == IDLE) ? DataMemResp_Data_In
                                         : r_wdata;

  data_mem_ram #(
    .DW(DW),
    .AW(AW)
  ) u_ram (
    .i_clk  (w_clk),
    .i_rst_n(w_rst_n),
    .i_we   (w_we),
    .i_re   (w_re),
    .i_addr (w_ram_addr),
    .i_wdata(w_ram_wdata),
    .o_rdata(w_rdata)
  );

  assign DataMemResp_Data_Out = w_rdata;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three wait-state variants, each
// driven by directed and random requests against a reference model.
module tb_data_mem_responder;

  localparam int NI = 3;

  int n_cmp = 0;
  int n_bad = 0;
  bit done [NI];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input int inst, input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL u%0d %s actual=%h required=%h t=%0t",
               inst, nm, act, exp, $time);
    end
  endtask

  genvar g;
  for (g = 0; g < NI; g++) begin : u
    localparam int WS = (g == 0) ? 0 : (g == 1) ? 2 : 3;

    logic        rst_n;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        ack;
    logic        err;

    data_mem_responder #(
      .DATAWIDTH_BUS     (32),
      .DATAWIDTH_MEM_ADDR(8),
      .WAIT_STATES       (WS)
    ) dut (
      .DataMemResp_CLOCK_50   (clk),
      .DataMemResp_RESET_InLow(rst_n),
      .DataMemResp_Selector_RD(rd),
      .DataMemResp_Selector_WR(wr),
      .DataMemResp_Address_In (addr),
      .DataMemResp_Data_In    (din),
      .DataMemResp_Data_Out   (dout),
      .DataMemResp_Ack_Out    (ack),
      .DataMemResp_Error_Out  (err)
    );

    // Reference model: word array, held read data, one pending access.
    logic [31:0] mem [256];
    logic [31:0] m_dout;
    int          cyc;
    bit          pend;
    bit          p_err;
    bit          p_rd;
    int          p_cyc;
    logic [7:0]  p_idx;
    logic [31:0] p_data;

    initial begin
      bit rs;
      bit e_ack;
      bit e_err;
      cyc    = 0;
      pend   = 1'b0;
      m_dout = '0;
      forever begin
        @(posedge clk);
        rs = !rst_n;
        cyc++;
        #1;
        e_ack = 1'b0;
        e_err = 1'b0;
        if (rs) begin
          pend   = 1'b0;
          m_dout = '0;
        end else if (pend && cyc == p_cyc) begin
          e_ack = 1'b1;
          e_err = p_err;
          if (!p_err) begin
            if (p_rd) m_dout = mem[p_idx];
            else      mem[p_idx] = p_data;
          end
          pend = 1'b0;
        end
        chk(g, "ack", {31'b0, ack}, {31'b0, e_ack});
        chk(g, "err", {31'b0, err}, {31'b0, e_err});
        chk(g, "dout", dout, m_dout);
      end
    end

    task automatic req(input bit r, input bit w,
                       input logic [31:0] a,
                       input logic [31:0] d,
                       input bit hold,
                       output int lat);
      int c;
      bit bad;
      @(negedge clk);
      c    = cyc;
      rd   = r;
      wr   = w;
      addr = a;
      din  = d;
      bad  = (r && w) || (a[1:0] != 2'b00) || ((a >> 10) != 0);
      p_err  = bad;
      p_rd   = r;
      p_idx  = a[9:2];
      p_data = d;
      p_cyc  = bad ? c + 1 : (r ? c + 2 + WS : c + 1 + WS);
      pend   = 1'b1;
      lat = -1;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (ack) begin
          lat = cyc - c;
          break;
        end
      end
      if (lat < 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL u%0d ack_timeout actual=none required=ack", g);
      end
      if (!hold) begin
        rd = 1'b0;
        wr = 1'b0;
      end
      repeat ($urandom_range(1, 3)) @(negedge clk);
    endtask

    initial begin
      int lat;
      int n;
      int k;
      int idx;
      logic [31:0] a;
      logic [31:0] rst_new;
      rst_n = 1'b0;
      rd    = 1'b0;
      wr    = 1'b0;
      addr  = '0;
      din   = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      req(0, 1, 32'h10, 32'hDEADBEEF, 0, lat);
      chk(g, "wr_lat", lat, 1 + WS);
      req(1, 0, 32'h10, 32'h0, 0, lat);
      chk(g, "rd_lat", lat, 2 + WS);
      chk(g, "rd_data", dout, 32'hDEADBEEF);

      req(1, 0, 32'h13, 32'h0, 0, lat);
      chk(g, "misal_lat", lat, 1);
      chk(g, "misal_keep", dout, 32'hDEADBEEF);

      req(0, 1, 32'h0, 32'h12345678, 0, lat);
      req(0, 1, 32'h400, 32'hFFFFFFFF, 0, lat);
      chk(g, "oor_lat", lat, 1);
      req(1, 0, 32'h0, 32'h0, 0, lat);
      chk(g, "oor_nowrite", dout, 32'h12345678);

      req(1, 1, 32'h8, 32'h0, 0, lat);
      chk(g, "both_lat", lat, 1);

      req(1, 0, 32'h10, 32'h0, 1, lat);
      chk(g, "held_lat", lat, 2 + WS);
      n = 0;
      repeat (8) begin
        @(negedge clk);
        if (ack) n++;
      end
      chk(g, "held_extra_acks", n, 0);
      rd = 1'b0;
      @(negedge clk);
      req(1, 0, 32'h10, 32'h0, 0, lat);
      chk(g, "rereq_lat", lat, 2 + WS);

      req(0, 1, 32'h20, 32'h00002020, 0, lat);
      req(1, 0, 32'h20, 32'h0, 0, lat);
      chk(g, "rd20", dout, 32'h00002020);

      // Write 0x20 then reset one cycle later.
      rst_new = 32'hBAD0BAD0;
      @(negedge clk);
      wr     = 1'b1;
      addr   = 32'h20;
      din    = rst_new;
      p_err  = 1'b0;
      p_rd   = 1'b0;
      p_idx  = 8'h08;
      p_data = rst_new;
      p_cyc  = cyc + 1 + WS;
      pend   = 1'b1;
      @(negedge clk);
      rst_n = 1'b0;
      wr    = 1'b0;
      @(negedge clk);
      chk(g, "dout_after_rst", dout, 32'h0);
      chk(g, "ack_after_rst", {31'b0, ack}, 32'h0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      req(1, 0, 32'h20, 32'h0, 0, lat);
      chk(g, "rd20_after_rst", dout,
          (WS == 0) ? 32'hBAD0BAD0 : 32'h00002020);

      for (int i = 0; i < 16; i++)
        req(0, 1, 32'(i * 4), $urandom, 0, lat);
      for (int i = 0; i < 60; i++) begin
        k   = $urandom_range(0, 9);
        idx = $urandom_range(0, 15);
        a   = 32'(idx * 4);
        if (k == 0)      req(1, 1, a, $urandom, 0, lat);
        else if (k == 1) req(1, 0, a + 32'($urandom_range(1, 3)),
                             0, 0, lat);
        else if (k == 2) req(0, 1, a | 32'h400 | ($urandom << 11),
                             $urandom, 0, lat);
        else if (k < 7)  req(1, 0, a, 0, 0, lat);
        else             req(0, 1, a, $urandom, 0, lat);
      end
      repeat (4) @(negedge clk);
      done[g] = 1'b1;
    end
  end

  initial begin
    bit all;
    all = 1'b0;
    for (int t = 0; t < 30000 && !all; t++) begin
      @(posedge clk);
      all = done[0] && done[1] && done[2];
    end
    if (!all) begin
      n_cmp++;
      n_bad++;
      $display("FAIL run_timeout actual=unfinished required=done");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
